freq_bram_acc: RTL and testbench

Single-clock, multi-channel frequency-bin RAM with a pipelined read-modify-write (RMW) port for sliding-DFT bin updates, plus an independent read port for display and streaming readout. Each entry holds CHANNELS signed words, for example real and imaginary. Supports accumulate and overwrite operations, optional saturation, forwarding for back-to-back updates to the same bin, and a clear-sweep state machine that zeroes every entry. Sits between the SDFT datapath (RMW side) and the output or visualiser logic (read side).

---
 rtl/freq_bram_acc.sv | 151 +++++++++++++++
 tb/tb_freq_bram_acc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_bram_acc.sv
// Multi-channel frequency-bin RAM: pipelined read-modify-write port with forwarding,
// independent registered read port and a zeroing clear sweep.
module freq_bram_acc #(
    parameter int unsigned addr_w   = 7,
    parameter int unsigned data_w   = 8,
    parameter int unsigned CHANNELS = 2,
    parameter bit          SAT      = 1'b1,
    parameter              FILE     = ""
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    output logic                         busy,
    input  logic                         rmw_en,
    output logic                         rmw_ready,
    input  logic                         rmw_op,
    input  logic [addr_w-1:0]            rmw_addr,
    input  logic [CHANNELS*data_w-1:0]   rmw_delta,
    output logic                         res_valid,
    output logic [addr_w-1:0]            res_addr,
    output logic [CHANNELS*data_w-1:0]   res_data,
    output logic                         ovf,
    input  logic                         r_en,
    input  logic [addr_w-1:0]            r_addr,
    output logic [CHANNELS*data_w-1:0]   r_data
);

    localparam int unsigned DEPTH = 1 << addr_w;
    localparam int unsigned BUS_W = CHANNELS * data_w;

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [BUS_W-1:0]  mem [DEPTH];
    state_t            state;
    logic [addr_w-1:0] cnt;

    logic              s1_valid;
    logic              s1_op;
    logic [addr_w-1:0] s1_addr;
    logic [BUS_W-1:0]  s1_delta;
    logic [BUS_W-1:0]  s1_stored;

    logic [BUS_W-1:0]  result_c;
    logic              ovf_c;
    logic              accept;

    assign rmw_ready = ~busy;
    assign accept    = rmw_en & ~busy;

    // Per-channel add/overwrite of the stage-1 operand; no carry crosses channels.
    always_comb begin
        result_c = '0;
        ovf_c    = 1'b0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            logic [data_w-1:0] ch_s;
            logic [data_w-1:0] ch_d;
            logic [data_w:0]   ch_sum;
            ch_s   = s1_stored[c*data_w +: data_w];
            ch_d   = s1_delta[c*data_w +: data_w];
            ch_sum = {ch_s[data_w-1], ch_s} + {ch_d[data_w-1], ch_d};
            if (s1_op) begin
                result_c[c*data_w +: data_w] = ch_d;
            end else if (ch_sum[data_w] != ch_sum[data_w-1]) begin
                ovf_c = 1'b1;
                if (SAT) begin
                    result_c[c*data_w +: data_w] = ch_sum[data_w] ? {1'b1, {(data_w-1){1'b0}}}
                                                                  : {1'b0, {(data_w-1){1'b1}}};
                end else begin
                    result_c[c*data_w +: data_w] = ch_sum[data_w-1:0];
                end
            end else begin
                result_c[c*data_w +: data_w] = ch_sum[data_w-1:0];
            end
        end
    end

    // Sweep FSM, RMW stage 1, result outputs, sticky overflow and read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_op     <= 1'b0;
            s1_addr   <= '0;
            s1_delta  <= '0;
            s1_stored <= '0;
            res_valid <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            ovf       <= 1'b0;
            r_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            s1_valid <= accept;
            if (accept) begin
                s1_op    <= rmw_op;
                s1_addr  <= rmw_addr;
                s1_delta <= rmw_delta;
                // A result retiring this edge is newer than the RAM copy.
                s1_stored <= (s1_valid && (s1_addr == rmw_addr)) ? result_c : mem[rmw_addr];
            end

            res_valid <= s1_valid;
            if (s1_valid) begin
                res_addr <= s1_addr;
                res_data <= result_c;
            end

            if (state == CLEAR || (state == IDLE && clear)) begin
                ovf <= 1'b0;
            end else if (s1_valid && ovf_c) begin
                ovf <= 1'b1;
            end

            if (r_en) begin
                r_data <= mem[r_addr];
            end
        end
    end

    // RAM writes: RMW writeback first so a same-edge sweep write to that entry wins.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (s1_valid) begin
                mem[s1_addr] <= result_c;
            end
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_freq_bram_acc.sv
// Randomized and directed bench for freq_bram_acc; a saturating and a wrapping
// instance share stimulus and are checked against a transaction-level model.
module tb_freq_bram_acc;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned CH    = 2;
    localparam int unsigned BW    = CH * DW;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n, clear, rmw_en, rmw_op, r_en;
    logic [AW-1:0] rmw_addr, r_addr;
    logic [BW-1:0] rmw_delta;

    logic          busy, rmw_ready, res_valid, ovf;
    logic [AW-1:0] res_addr;
    logic [BW-1:0] res_data, r_data;
    logic          w_busy, w_ready, w_res_valid, w_ovf;
    logic [AW-1:0] w_res_addr;
    logic [BW-1:0] w_res_data, w_r_data;

    freq_bram_acc #(.addr_w(AW), .data_w(DW), .CHANNELS(CH), .SAT(1'b1), .FILE("")) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .busy(busy),
        .rmw_en(rmw_en), .rmw_ready(rmw_ready), .rmw_op(rmw_op), .rmw_addr(rmw_addr),
        .rmw_delta(rmw_delta), .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
        .ovf(ovf), .r_en(r_en), .r_addr(r_addr), .r_data(r_data)
    );

    freq_bram_acc #(.addr_w(AW), .data_w(DW), .CHANNELS(CH), .SAT(1'b0), .FILE("")) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .busy(w_busy),
        .rmw_en(rmw_en), .rmw_ready(w_ready), .rmw_op(rmw_op), .rmw_addr(rmw_addr),
        .rmw_delta(rmw_delta), .res_valid(w_res_valid), .res_addr(w_res_addr), .res_data(w_res_data),
        .ovf(w_ovf), .r_en(r_en), .r_addr(r_addr), .r_data(w_r_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: committed RAM image, latest logical value, one in-flight result.
    logic [BW-1:0] com_s [DEPTH];
    logic [BW-1:0] com_w [DEPTH];
    logic [BW-1:0] lat_s [DEPTH];
    logic [BW-1:0] lat_w [DEPTH];
    bit            m_busy;
    int            m_cnt;
    bit            m_ovf_s, m_ovf_w;
    logic [BW-1:0] m_rs, m_rw;
    bit            p_valid, p_os, p_ow;
    logic [AW-1:0] p_addr;
    logic [BW-1:0] p_s, p_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] upd(input logic [BW-1:0] old, input logic [BW-1:0] d,
                                          input bit op, input bit sat, output bit ov);
        logic [BW-1:0]   r;
        logic signed [DW-1:0] ta, tb;
        int a, b, s;
        ov = 1'b0;
        r  = '0;
        for (int c = 0; c < int'(CH); c++) begin
            ta = old[c*DW +: DW];
            tb = d[c*DW +: DW];
            a  = int'(ta);
            b  = int'(tb);
            s  = op ? b : a + b;
            if (!op && (s > 127 || s < -128)) begin
                ov = 1'b1;
                if (sat) s = (s > 127) ? 127 : -128;
            end
            r[c*DW +: DW] = DW'(s);
        end
        return r;
    endfunction

    task automatic tick();
        bit            acc, rd, start, os, ow;
        logic [AW-1:0] na;
        logic [BW-1:0] ns, nw;
        os = 1'b0; ow = 1'b0; na = '0; ns = '0; nw = '0;
        acc = rmw_en && !m_busy;
        if (acc) begin
            na = rmw_addr;
            ns = upd(lat_s[na], rmw_delta, rmw_op, 1'b1, os);
            nw = upd(lat_w[na], rmw_delta, rmw_op, 1'b0, ow);
            lat_s[na] = ns;
            lat_w[na] = nw;
        end
        rd = r_en;
        if (rd) begin
            m_rs = com_s[r_addr];
            m_rw = com_w[r_addr];
        end
        start = clear && !m_busy;
        @(posedge clk);
        #1;
        if (p_valid) begin
            com_s[p_addr] = p_s;
            com_w[p_addr] = p_w;
            if (p_os) m_ovf_s = 1'b1;
            if (p_ow) m_ovf_w = 1'b1;
        end
        if (m_busy) begin
            com_s[m_cnt] = '0; com_w[m_cnt] = '0;
            lat_s[m_cnt] = '0; lat_w[m_cnt] = '0;
            m_ovf_s = 1'b0; m_ovf_w = 1'b0;
            m_cnt++;
            if (m_cnt == int'(DEPTH)) m_busy = 1'b0;
        end
        if (start) begin
            m_busy = 1'b1; m_cnt = 0;
            m_ovf_s = 1'b0; m_ovf_w = 1'b0;
        end
        check("res_valid", 32'(res_valid), 32'(p_valid));
        check("w_res_valid", 32'(w_res_valid), 32'(p_valid));
        if (p_valid) begin
            check("res_addr", 32'(res_addr), 32'(p_addr));
            check("res_data", 32'(res_data), 32'(p_s));
            check("w_res_data", 32'(w_res_data), 32'(p_w));
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("rmw_ready", 32'(rmw_ready), 32'(!m_busy));
        check("ovf", 32'(ovf), 32'(m_ovf_s));
        check("w_ovf", 32'(w_ovf), 32'(m_ovf_w));
        check("r_data", 32'(r_data), 32'(m_rs));
        check("w_r_data", 32'(w_r_data), 32'(m_rw));
        p_valid = acc; p_addr = na; p_s = ns; p_w = nw; p_os = os; p_ow = ow;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        m_busy = 1'b0; p_valid = 1'b0;
        m_ovf_s = 1'b0; m_ovf_w = 1'b0;
        m_rs = '0; m_rw = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            lat_s[i] = com_s[i];
            lat_w[i] = com_w[i];
        end
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_addr", 32'(res_addr), 32'(0));
        check("rst_res_data", 32'(res_data), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_r_data", 32'(r_data), 32'(0));
        reset_n = 1'b1;
    endtask

    task automatic rmw(input bit op, input logic [AW-1:0] a, input logic [BW-1:0] d);
        rmw_en = 1'b1; rmw_op = op; rmw_addr = a; rmw_delta = d;
        tick();
        rmw_en = 1'b0;
    endtask

    task automatic sweep();
        int n_busy;
        n_busy = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            n_busy++;
            tick();
        end
        check("sweep_len", 32'(n_busy), 32'(DEPTH));
    endtask

    task automatic read(input logic [AW-1:0] a);
        r_en = 1'b1; r_addr = a;
        tick();
        r_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; rmw_en = 1'b0; rmw_op = 1'b0;
        rmw_addr = '0; rmw_delta = '0; r_en = 1'b0; r_addr = '0;
        m_busy = 1'b0; m_cnt = 0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
        m_rs = '0; m_rw = '0; p_valid = 1'b0; p_os = 1'b0; p_ow = 1'b0;
        p_addr = '0; p_s = '0; p_w = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            com_s[i] = '0; com_w[i] = '0; lat_s[i] = '0; lat_w[i] = '0;
        end

        do_reset();
        do_reset();
        sweep();
        for (int i = 0; i < int'(DEPTH); i++) begin
            read(AW'(i));
            check("clr_read", 32'(r_data), 32'h0000);
        end

        // Overwrite then accumulate; ch1 lives in the upper byte.
        rmw(1'b1, 4'd3, 16'h10F0);
        rmw(1'b0, 4'd3, 16'h0502);
        tick();
        check("ovw_add_res", 32'(res_data), 32'h15F2);
        read(4'd3);
        check("ovw_add_read", 32'(r_data), 32'h15F2);

        // Four back-to-back increments of one bin.
        for (int k = 0; k < 5; k++) begin
            rmw_en = (k < 4); rmw_op = 1'b0; rmw_addr = 4'd5; rmw_delta = 16'h0101;
            tick();
            if (k >= 1) check("fwd_seq", 32'(res_data), 32'(k * 16'h0101));
        end
        rmw_en = 1'b0;

        // Overflow on both channels, saturating and wrapping variants.
        rmw(1'b1, 4'd7, 16'h7E81);
        rmw(1'b0, 4'd7, 16'h05FB);
        tick();
        check("sat_res", 32'(res_data), 32'h7F80);
        check("wrap_res", 32'(w_res_data), 32'h837C);
        check("sat_ovf", 32'(ovf), 32'h1);
        check("wrap_ovf", 32'(w_ovf), 32'h1);

        // Sweep clears ovf; requests during the sweep are dropped.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rmw_en = 1'b1; rmw_op = 1'b1; rmw_addr = 4'd9; rmw_delta = 16'h1234;
        for (int i = 0; i < 40 && busy; i++) begin
            check("sweep_ready", 32'(rmw_ready), 32'h0);
            tick();
        end
        rmw_en = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'h0);
        read(4'd9);
        check("drop_read", 32'(r_data), 32'h0000);

        // Reset part-way through a sweep leaves upper entries intact.
        for (int i = 0; i < int'(DEPTH); i++) rmw(1'b1, AW'(i), 16'h1100 + 16'(i));
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        tick();
        check("rst_mid_busy", 32'(busy), 32'h0);
        for (int i = 0; i < int'(DEPTH); i++) read(AW'(i));
        check("rst_mid_keep", 32'(r_data), 32'h110F);
        read(4'd2);
        check("rst_mid_zeroed", 32'(r_data), 32'h0000);

        // Read-before-write on the same edge.
        sweep();
        rmw(1'b1, 4'd2, 16'h0101);
        tick();
        rmw_en = 1'b1; rmw_op = 1'b0; rmw_addr = 4'd2; rmw_delta = 16'h0101;
        tick();
        rmw_en = 1'b0;
        read(4'd2);
        check("rbw_old", 32'(r_data), 32'h0101);
        read(4'd2);
        check("rbw_new", 32'(r_data), 32'h0202);

        // Random traffic concentrated on a few bins to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            rmw_en    = ($urandom_range(3) != 0);
            rmw_op    = ($urandom_range(4) == 0);
            rmw_addr  = AW'($urandom_range(3));
            rmw_delta = BW'($urandom);
            r_en      = ($urandom_range(1) != 0);
            r_addr    = AW'($urandom_range(DEPTH - 1));
            tick();
        end
        rmw_en = 1'b0; r_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) read(AW'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
